// File: rtl/id_hazard_scoreboard_if.sv
// ============================================================================
// Module   : id_hazard_scoreboard_if
// Brief    : Decode-stage operand/issue bundle for id_hazard_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_hazard_scoreboard_if #(
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int NRD  = 2,
    parameter int NFWD = 3,
    parameter int LW   = 3
);
    logic                hold;
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*DW-1:0]   rf_rdata;
    logic [NFWD-1:0]     fwd_we;
    logic [NFWD*AW-1:0]  fwd_waddr;
    logic [NFWD*DW-1:0]  fwd_wdata;
    logic                issue_valid;
    logic                issue_we;
    logic [AW-1:0]       issue_waddr;
    logic [LW-1:0]       issue_lat;
    logic [NRD*DW-1:0]   rdata;
    logic                stallreq;
    logic                issue_ack;

    modport master (
        output hold, rd_en, rd_addr, rf_rdata, fwd_we, fwd_waddr, fwd_wdata,
               issue_valid, issue_we, issue_waddr, issue_lat,
        input  rdata, stallreq, issue_ack
    );

    modport slave (
        input  hold, rd_en, rd_addr, rf_rdata, fwd_we, fwd_waddr, fwd_wdata,
               issue_valid, issue_we, issue_waddr, issue_lat,
        output rdata, stallreq, issue_ack
    );
endinterface

`default_nettype wire

// File: rtl/id_hazard_scoreboard.sv
// ============================================================================
// Module   : id_hazard_scoreboard
// Brief    : Decode operand forwarding plus per-register latency scoreboard.
//            Optional perf counters enabled by macro ID_HZD_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_hazard_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int NRD  = 2,
    parameter int NFWD = 3,
    parameter int LW   = 3
) (
    input  wire logic              clk,
    input  wire logic              rst,
    id_hazard_scoreboard_if.slave  bus
`ifdef ID_HZD_PERF_EN
    ,
    output logic [31:0]            perf_stall_cycles,
    output logic [31:0]            perf_raw_events
`endif
);
    localparam int c_NSLOT = 1 << AW;

    logic [LW-1:0] r_cnt [1:NREG-1];
    logic [LW-1:0] w_cnt [c_NSLOT];
    logic [DW-1:0] w_rdata [NRD];
    logic [NRD-1:0] w_raw;
    logic          w_waw;
    logic          w_stall;
    logic          w_ack;
    logic          w_set;

    // Address-indexed view of the scoreboard; r0 and any slot beyond NREG read as idle.
    for (genvar s = 0; s < c_NSLOT; s++) begin : g_slot
        if (s > 0 && s < NREG) begin : g_live
            assign w_cnt[s] = r_cnt[s];
        end else begin : g_dead
            assign w_cnt[s] = '0;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_port
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_fwd_data;
        logic          w_fwd_hit;

        assign w_addr = bus.rd_addr[k*AW +: AW];

        // Walk from oldest to youngest so the lowest matching index wins.
        always_comb begin
            w_fwd_hit  = 1'b0;
            w_fwd_data = '0;
            for (int i = NFWD - 1; i >= 0; i--) begin
                if (bus.fwd_we[i] && bus.fwd_waddr[i*AW +: AW] == w_addr) begin
                    w_fwd_hit  = 1'b1;
                    w_fwd_data = bus.fwd_wdata[i*DW +: DW];
                end
            end
        end

        assign w_rdata[k] = (w_addr == '0) ? '0 :
                            w_fwd_hit      ? w_fwd_data :
                                             bus.rf_rdata[k*DW +: DW];
        assign w_raw[k]   = bus.rd_en[k] && (w_addr != '0) && (w_cnt[w_addr] != '0);
    end

    always_comb begin
        bus.rdata = '0;
        for (int k = 0; k < NRD; k++) begin
            bus.rdata[k*DW +: DW] = w_rdata[k];
        end
    end

    assign w_waw   = bus.issue_valid && bus.issue_we && (bus.issue_waddr != '0) &&
                     (w_cnt[bus.issue_waddr] != '0);
    assign w_stall = !rst && bus.issue_valid && ((|w_raw) || w_waw);
    assign w_ack   = !rst && bus.issue_valid && !w_stall && !bus.hold;
    assign w_set   = w_ack && bus.issue_we && (bus.issue_waddr != '0) && (bus.issue_lat != '0);

    assign bus.stallreq  = w_stall;
    assign bus.issue_ack = w_ack;

    // A fresh issue overrides the decrement of the same entry.
    always_ff @(posedge clk) begin
        for (int r = 1; r < NREG; r++) begin
            if (rst) begin
                r_cnt[r] <= '0;
            end else if (w_set && bus.issue_waddr == AW'(r)) begin
                r_cnt[r] <= bus.issue_lat;
            end else if (!bus.hold && r_cnt[r] != '0) begin
                r_cnt[r] <= r_cnt[r] - LW'(1);
            end
        end
    end

`ifdef ID_HZD_PERF_EN
    logic        r_stall_q;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_q    <= 1'b0;
            r_perf_stall <= '0;
            r_perf_raw   <= '0;
        end else begin
            r_stall_q <= w_stall;
            if (w_stall && r_perf_stall != '1) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_stall && !r_stall_q && (|w_raw) && r_perf_raw != '1) begin
                r_perf_raw <= r_perf_raw + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_raw_events   = r_perf_raw;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_hazard_scoreboard.sv
// ============================================================================
// Module   : tb_id_hazard_scoreboard
// Brief    : Directed bench: forwarding vector table plus scoreboard sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_hazard_scoreboard;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NRD  = 2;
    localparam int NFWD = 3;
    localparam int LW   = 3;

    localparam logic [31:0] c_A   = 32'hAAAA_0001;
    localparam logic [31:0] c_B   = 32'hBBBB_0002;
    localparam logic [31:0] c_C   = 32'hCCCC_0003;
    localparam logic [31:0] c_RF0 = 32'h1111_0000;
    localparam logic [31:0] c_RF1 = 32'h2222_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    id_hazard_scoreboard_if #(.AW(AW), .DW(DW), .NRD(NRD), .NFWD(NFWD), .LW(LW)) bus ();

`ifdef ID_HZD_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_raw_events;
`endif

    id_hazard_scoreboard #(
        .NREG(NREG), .AW(AW), .DW(DW), .NRD(NRD), .NFWD(NFWD), .LW(LW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus)
`ifdef ID_HZD_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_raw_events   (perf_raw_events)
`endif
    );

    typedef struct {
        string       name;
        logic [2:0]  fwd_we;
        logic [4:0]  w0, w1, w2;
        logic [4:0]  a0, a1;
        logic [31:0] exp0, exp1;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.hold        = 1'b0;
        bus.rd_en       = '0;
        bus.rd_addr     = '0;
        bus.rf_rdata    = {c_RF1, c_RF0};
        bus.fwd_we      = '0;
        bus.fwd_waddr   = '0;
        bus.fwd_wdata   = {c_C, c_B, c_A};
        bus.issue_valid = 1'b0;
        bus.issue_we    = 1'b0;
        bus.issue_waddr = '0;
        bus.issue_lat   = '0;
    endtask

    task automatic issue_w(input logic [4:0] waddr, input logic [2:0] lat);
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_we    = 1'b1;
        bus.issue_waddr = waddr;
        bus.issue_lat   = lat;
    endtask

    task automatic issue_rd(input logic [4:0] raddr);
        idle();
        bus.issue_valid = 1'b1;
        bus.rd_en       = 2'b01;
        bus.rd_addr     = {5'd0, raddr};
    endtask

    // Counts consecutive stalled cycles with inputs held; leaves time at the first free cycle.
    task automatic count_stalls(input string name, input int exp);
        int n;
        n = 0;
        settle();
        for (int c = 0; c < 20; c++) begin
            if (!bus.stallreq) break;
            n++;
            tick();
            settle();
        end
        chk(name, n, exp);
    endtask

    initial begin
        vecs[0] = '{"fwd_all_idx0",    3'b111, 5'd8,  5'd8, 5'd8, 5'd8,  5'd3, c_A,   c_RF1};
        vecs[1] = '{"fwd_idx1",        3'b110, 5'd8,  5'd8, 5'd8, 5'd8,  5'd3, c_B,   c_RF1};
        vecs[2] = '{"fwd_idx2",        3'b100, 5'd8,  5'd8, 5'd8, 5'd8,  5'd3, c_C,   c_RF1};
        vecs[3] = '{"fwd_none",        3'b000, 5'd8,  5'd8, 5'd8, 5'd8,  5'd8, c_RF0, c_RF1};
        vecs[4] = '{"r0_zero",         3'b111, 5'd0,  5'd0, 5'd0, 5'd0,  5'd0, 32'd0, 32'd0};
        vecs[5] = '{"fwd_split",       3'b111, 5'd5,  5'd8, 5'd8, 5'd8,  5'd5, c_B,   c_A};
        vecs[6] = '{"fwd_lo_pair",     3'b011, 5'd7,  5'd7, 5'd7, 5'd7,  5'd9, c_A,   c_RF1};
        vecs[7] = '{"fwd_two_ports",   3'b101, 5'd31, 5'd8, 5'd8, 5'd31, 5'd8, c_A,   c_C};

        // Reset behaviour: outputs gated while rst is high.
        idle();
        rst = 1'b1;
        issue_rd(5'd5);
        settle();
        chk("rst_stallreq", 32'(bus.stallreq), 32'd0);
        chk("rst_ack", 32'(bus.issue_ack), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("post_rst_stall", 32'(bus.stallreq), 32'd0);
        chk("post_rst_ack", 32'(bus.issue_ack), 32'd1);
        tick();

        // Forwarding vector table.
        for (int v = 0; v < 8; v++) begin
            idle();
            bus.issue_valid = 1'b1;
            bus.rd_en       = 2'b11;
            bus.rd_addr     = {vecs[v].a1, vecs[v].a0};
            bus.fwd_we      = vecs[v].fwd_we;
            bus.fwd_waddr   = {vecs[v].w2, vecs[v].w1, vecs[v].w0};
            settle();
            chk({vecs[v].name, "_rdata0"}, bus.rdata[31:0], vecs[v].exp0);
            chk({vecs[v].name, "_rdata1"}, bus.rdata[63:32], vecs[v].exp1);
            chk({vecs[v].name, "_stall"}, 32'(bus.stallreq), 32'd0);
            tick();
        end

        // Load-use with latency 1.
        issue_w(5'd8, 3'd1);
        settle();
        chk("lu_prod_ack", 32'(bus.issue_ack), 32'd1);
        tick();
        issue_rd(5'd8);
        settle();
        chk("lu_stall", 32'(bus.stallreq), 32'd1);
        chk("lu_stall_ack", 32'(bus.issue_ack), 32'd0);
        tick();
        bus.fwd_we    = 3'b010;
        bus.fwd_waddr = {5'd0, 5'd8, 5'd0};
        settle();
        chk("lu_free", 32'(bus.stallreq), 32'd0);
        chk("lu_fwd_data", bus.rdata[31:0], c_B);
        chk("lu_free_ack", 32'(bus.issue_ack), 32'd1);
        tick();

        // Long latency 5, then an unrelated reader is not held up.
        issue_w(5'd9, 3'd5);
        tick();
        issue_rd(5'd9);
        count_stalls("lat5_stalls", 5);
        tick();
        issue_w(5'd9, 3'd5);
        tick();
        issue_rd(5'd3);
        settle();
        chk("lat5_other_stall", 32'(bus.stallreq), 32'd0);
        chk("lat5_other_ack", 32'(bus.issue_ack), 32'd1);
        tick();
        idle();
        for (int c = 0; c < 6; c++) tick();

        // Hold freezes the countdown and blocks issue.
        issue_w(5'd10, 3'd3);
        tick();
        issue_rd(5'd10);
        bus.hold = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("hold_ack", 32'(bus.issue_ack), 32'd0);
            tick();
        end
        bus.hold = 1'b0;
        count_stalls("hold_release_stalls", 3);
        tick();

        // WAW stall, then lat=0 leaves nothing pending.
        issue_w(5'd11, 3'd4);
        tick();
        issue_w(5'd11, 3'd0);
        count_stalls("waw_stalls", 4);
        chk("waw_ack", 32'(bus.issue_ack), 32'd1);
        tick();
        issue_rd(5'd11);
        settle();
        chk("lat0_no_track", 32'(bus.stallreq), 32'd0);
        tick();

        // Writes to r0 are never tracked.
        issue_w(5'd0, 3'd7);
        settle();
        chk("r0_issue_ack", 32'(bus.issue_ack), 32'd1);
        tick();
        issue_rd(5'd0);
        bus.issue_we = 1'b1;
        settle();
        chk("r0_no_stall", 32'(bus.stallreq), 32'd0);
        chk("r0_rdata", bus.rdata[31:0], 32'd0);
        tick();

        // Reset mid-flight drops pending entries.
        issue_w(5'd12, 3'd6);
        tick();
        issue_rd(5'd12);
        rst = 1'b1;
        settle();
        chk("midrst_stall", 32'(bus.stallreq), 32'd0);
        chk("midrst_ack", 32'(bus.issue_ack), 32'd0);
        tick();
        rst = 1'b0;
        settle();
        chk("after_rst_stall", 32'(bus.stallreq), 32'd0);
        chk("after_rst_ack", 32'(bus.issue_ack), 32'd1);
`ifdef ID_HZD_PERF_EN
        chk("perf_stall_rst", perf_stall_cycles, 32'd0);
        chk("perf_raw_rst", perf_raw_events, 32'd0);
`endif
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
Parametrised operand-hazard unit for the decode stage. It replaces fixed two-port, three-source forwarding and single-cycle load-use detection with:
- N read ports.
- N prioritised forwarding sources.
- A per-register countdown scoreboard that tracks multi-cycle producers (loads, mul/div) of arbitrary latency.

It sits between the regfile read ports and the decode outputs. It drives operand data to EX and stallreq to the stall controller.

Parameters:
NREG, 32, number of architectural registers; register 0 is hard-wired zero
AW, 5, register address width (clog2 NREG)
DW, 32, data width
NRD, 2, number of read ports
NFWD, 3, number of forwarding sources; index 0 is the youngest stage and has the highest priority
LW, 3, latency counter width; maximum tracked latency is 2^LW-1

Ports:
clk  in  1  clock
rst  in  1  reset
hold  in  1  downstream stall; freezes counters and blocks issue
rd_en  in  NRD  per-port read valid
rd_addr  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW]
rf_rdata  in  NRD*DW  raw regfile data per port
fwd_we  in  NFWD  forwarding source write enable
fwd_waddr  in  NFWD*AW  forwarding destination addresses
fwd_wdata  in  NFWD*DW  forwarding data
issue_valid  in  1  decode is issuing an instruction this cycle
issue_we  in  1  the issuing instruction writes a register
issue_waddr  in  AW  destination register of the issuing instruction
issue_lat  in  LW  cycles until the result appears on a fwd source; 0 means a normal ALU op
rdata  out  NRD*DW  resolved operands
stallreq  out  1  decode must stall
issue_ack  out  1  issue accepted; equals issue_valid & ~stallreq & ~hold

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset, all cnt[r] are cleared to 0. While rst=1, stallreq=0 and issue_ack=0.
- State: cnt[r] is an LW-bit counter for r=1..NREG-1. Register r is pending when cnt[r]!=0. cnt[0] is constant 0.
- Operand resolution (combinational, per port k):
  - If addr=0, rdata=0.
  - Otherwise rdata is fwd_wdata of the lowest index i with fwd_we[i] & fwd_waddr[i]==addr.
  - Otherwise rdata=rf_rdata[k].
  - rdata is driven regardless of rd_en.
- RAW stall: raw_k = rd_en[k] & addr!=0 & cnt[addr]!=0.
- WAW stall: waw = issue_valid & issue_we & issue_waddr!=0 & cnt[issue_waddr]!=0.
- stallreq = issue_valid & (OR of raw_k | waw). Forwarding never overrides a pending counter.
- Countdown: each clock with hold=0, every non-zero cnt decrements by 1. With hold=1, all counters hold.
- Issue set: on issue_ack & issue_we & issue_waddr!=0 & issue_lat!=0, cnt[issue_waddr] <= issue_lat. A set takes priority over a same-cycle decrement of that entry.
- Stall latency: a consumer issued directly after a producer with latency L stalls exactly L cycles (absent hold). On the first non-stalled cycle, the data arrives via the forwarding source.
- issue_lat=0 sets nothing. The result is covered by forwarding only.
- Writes to r0 are never tracked.
- Reset mid-operation: all pending entries are dropped, and the next cycle is stall-free.

Optional Feature:
Macro ID_HZD_PERF_EN.
- Defined: adds outputs perf_stall_cycles (32) and perf_raw_events (32).
  - perf_stall_cycles increments on every cycle with stallreq=1.
  - perf_raw_events increments on each rising edge of stallreq caused by a RAW hazard (waw alone does not count).
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- Not defined: the ports and counters are absent, and the remaining behaviour is identical.

Test Plan:
1. Forwarding priority: fwd_we=3'b111, all waddr=8, data A/B/C, rd_addr0=8 -> rdata0=A. Clear fwd_we[0] -> B. Read r0 with fwd_waddr=0 -> 0.
2. Load-use: issue r8 with lat=1 (ack=1); next cycle issue reading r8 -> stallreq=1 for exactly 1 cycle, then 0 with rdata = fwd_wdata[1].
3. Long latency: issue r9 with lat=5; a reader of r9 on the next cycle -> stallreq=1 for 5 consecutive cycles. Readers of other registers are not stalled once r9 is accepted.
4. Hold: issue r10 with lat=3, then hold=1 for 4 cycles -> cnt[r10] frozen at 3 and issue_ack=0. After release, 3 further stall cycles.
5. WAW and r0: issue r11 lat=4, then issue writing r11 with lat=0 -> stalled until cnt=0. Issue to r0 with lat=7 -> no later stall on r0 reads.
6. Reset mid-flight: pending r12 with cnt=6, pulse rst -> the next reader of r12 has stallreq=0. Under ID_HZD_PERF_EN, the perf counters read 0.
